// File: rtl/mulmod_arbiter_pkg.sv
// Shared types and width helpers for the multiplier arbiter and its
// round-robin picker.
package mulmod_arb_pkg;

  localparam int MM_DW = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mulmod_arbiter_if.sv
// Connection to the shared mul256mod engine: operands and start pulse out,
// result and done pulse back.
interface mulmod_arbiter_if
  import mulmod_arb_pkg::*;
#(
  parameter int DW = MM_DW
);
  logic [DW-1:0] mm_datax;
  logic [DW-1:0] mm_datay;
  logic          mm_update;
  logic [DW-1:0] mm_result;
  logic          mm_done;

  modport master (
    output mm_datax, mm_datay, mm_update,
    input  mm_result, mm_done
  );

  modport slave (
    input  mm_datax, mm_datay, mm_update,
    output mm_result, mm_done
  );
endinterface

// File: rtl/mulmod_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo N. Shared by several engine arbiters.
module rr_arbiter
  import mulmod_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  localparam int unsigned NU = N;

  // Walk offsets 1..N from the pointer; the first hit wins.
  always_comb begin
    int unsigned j;
    logic        hit;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 32'd0;
    hit   = 1'b0;
    for (int unsigned off = 32'd1; off <= NU; off++) begin
      j = 32'(ptr_i) + off;
      j = (j >= NU) ? (j - NU) : j;
      hit      = req_i[j] & ~any_o;
      gnt_o[j] = gnt_o[j] | hit;
      idx_o    = hit ? IW'(j) : idx_o;
      any_o    = any_o | req_i[j];
    end
  end
endmodule

// File: rtl/mulmod_arbiter.sv
// Time-shares one mul256mod engine among NREQ requesters: round-robin grant,
// one operation in flight, result routed back to its owner, done watchdog.
module mulmod_arbiter
  import mulmod_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DW          = MM_DW,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*DW-1:0] req_x_i,
  input  logic [NREQ*DW-1:0] req_y_i,
  output logic [NREQ-1:0]    req_ready_o,
  output logic [NREQ-1:0]    rsp_valid_o,
  output logic [DW-1:0]      rsp_data_o,
  output logic               rsp_err_o,
  output logic               busy_o,
  output logic               timeout_err_o,
  mulmod_arbiter_if.master   mm
);
  localparam int IW = idx_w(NREQ);
  localparam int WW = idx_w(TIMEOUT_CYC + 1);

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   owner_q;
  logic [WW-1:0]   wdog_q;
  logic [WW-1:0]   wdog_d;
  logic [DW-1:0]   datax_q;
  logic [DW-1:0]   datay_q;
  logic            update_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [NREQ-1:0] owner_oh_d;
  logic [DW-1:0]   rsp_data_q;
  logic            rsp_err_q;
  logic            busy_q;
  logic            timeout_err_q;

  logic [NREQ-1:0] gnt_s;
  logic [IW-1:0]   gidx_s;
  logic            any_s;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (gidx_s),
    .any_o (any_s)
  );

  assign wdog_d     = wdog_q + WW'(1);
  assign owner_oh_d = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

  // Accept is combinational so the requester sees it in its grant cycle.
  assign req_ready_o = (state_q == IDLE) ? gnt_s : {NREQ{1'b0}};

  // Operation sequencer; every engine-facing and response output is registered here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      ptr_q         <= IW'(NREQ - 1);
      owner_q       <= '0;
      wdog_q        <= '0;
      datax_q       <= '0;
      datay_q       <= '0;
      update_q      <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      update_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_s) begin
            owner_q  <= gidx_s;
            ptr_q    <= gidx_s;
            datax_q  <= req_x_i[gidx_s*DW +: DW];
            datay_q  <= req_y_i[gidx_s*DW +: DW];
            update_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
          end else begin
            state_q  <= IDLE;
          end
        end
        ISSUE: begin
          wdog_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          wdog_q <= wdog_d;
          // A done arriving on the timeout cycle still delivers the real result.
          if (mm.mm_done) begin
            rsp_data_q  <= mm.mm_result;
            rsp_valid_q <= owner_oh_d;
            state_q     <= RESP;
          end else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b1;
            rsp_valid_q   <= owner_oh_d;
            timeout_err_q <= 1'b1;
            state_q       <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mm.mm_datax   = datax_q;
  assign mm.mm_datay   = datay_q;
  assign mm.mm_update  = update_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = timeout_err_q;
endmodule

// File: tb/tb_mulmod_arbiter.sv
// Randomized self-checking bench: a 72-cycle multiplier model plus a
// reference built from round-robin order, latency rules and x*y mod modz.
module tb_mulmod_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 256;
  localparam int L    = 72;
  localparam logic [255:0] MODZ =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_x = '0;
  logic [NREQ*DW-1:0] req_y = '0;
  logic [NREQ-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err, busy, timeout_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mulmod_arbiter_if #(.DW(DW)) mmif();

  mulmod_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT_CYC(255)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid_i   (req_valid),
    .req_x_i       (req_x),
    .req_y_i       (req_y),
    .req_ready_o   (req_ready),
    .rsp_valid_o   (rsp_valid),
    .rsp_data_o    (rsp_data),
    .rsp_err_o     (rsp_err),
    .busy_o        (busy),
    .timeout_err_o (timeout_err),
    .mm            (mmif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] p;
    p = {256'd0, a} * {256'd0, b};
    p = p % {256'd0, MODZ};
    return p[255:0];
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference round-robin: first requester after ptr, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- multiplier model ----------------
  logic         m_done = 1'b0;
  logic [255:0] m_res = '0;
  logic         m_pend = 1'b0;
  int           m_cnt = 0;
  logic         never_done = 1'b0;
  logic         spur = 1'b0;

  assign mmif.mm_done   = m_done;
  assign mmif.mm_result = m_res;

  // Result is formed from the operands present at done time, so unstable operands show up.
  always @(posedge clk) begin
    if (!rstn) begin
      m_pend <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= spur;
      if (mmif.mm_update) begin
        m_pend <= 1'b1;
        m_cnt  <= L - 1;
      end else if (m_pend) begin
        if (m_cnt == 1) begin
          m_pend <= 1'b0;
          if (!never_done) begin
            m_done <= 1'b1;
            m_res  <= mulmod(mmif.mm_datax, mmif.mm_datay);
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // ---------------- event monitor ----------------
  int              g_cyc[$];
  logic [NREQ-1:0] g_vec[$];
  int              u_cyc[$];
  int              r_cyc[$];
  logic [NREQ-1:0] r_vec[$];
  logic [255:0]    r_data[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (req_ready != '0) begin
        g_cyc.push_back(cyc);
        g_vec.push_back(req_ready);
      end
      if (mmif.mm_update) u_cyc.push_back(cyc);
      if (rsp_valid != '0) begin
        r_cyc.push_back(cyc);
        r_vec.push_back(rsp_valid);
        r_data.push_back(rsp_data);
      end
    end
  end

  task automatic clear_logs();
    g_cyc.delete(); g_vec.delete(); u_cyc.delete();
    r_cyc.delete(); r_vec.delete(); r_data.delete();
  endtask

  task automatic issue(input int i, input logic [255:0] x, input logic [255:0] y, output int t);
    @(posedge clk); #1;
    req_x[i*DW +: DW] = x;
    req_y[i*DW +: DW] = y;
    req_valid[i] = 1'b1;
    t = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check_eq($sformatf("grant_wait_r%0d", i), 256'd0, 256'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output int tc, output logic [NREQ-1:0] v,
                          output logic [255:0] d, output logic e);
    tc = -1; v = '0; d = '0; e = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        tc = cyc; v = rsp_valid; d = rsp_data; e = rsp_err;
        break;
      end
    end
    if (tc < 0) check_eq("rsp_wait", 256'd0, 256'd1);
  endtask

  task automatic op_check(input string tag, input int i, input logic [255:0] x,
                          input logic [255:0] y, input logic [255:0] exp_d,
                          input logic exp_e, input int off);
    int t, tc;
    logic [NREQ-1:0] v;
    logic [255:0] d;
    logic e;
    clear_logs();
    issue(i, x, y, t);
    wait_rsp(off + 40, tc, v, d, e);
    check_eq({tag, "_upd_n"}, 256'(u_cyc.size()), 256'd1);
    if (u_cyc.size() > 0) check_eq({tag, "_upd_cyc"}, 256'(u_cyc[0]), 256'(t + 1));
    check_eq({tag, "_rsp_cyc"}, 256'(tc), 256'(t + off));
    check_eq({tag, "_rsp_vec"}, 256'(v), 256'(1 << i));
    check_eq({tag, "_rsp_data"}, d, exp_d);
    check_eq({tag, "_rsp_err"}, 256'(e), 256'(exp_e));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 256'(req_ready), 256'd0);
    check_eq({tag, "_rsp_valid"}, 256'(rsp_valid), 256'd0);
    check_eq({tag, "_rsp_data"}, rsp_data, 256'd0);
    check_eq({tag, "_rsp_err"}, 256'(rsp_err), 256'd0);
    check_eq({tag, "_busy"}, 256'(busy), 256'd0);
    check_eq({tag, "_tmo_err"}, 256'(timeout_err), 256'd0);
    check_eq({tag, "_datax"}, mmif.mm_datax, 256'd0);
    check_eq({tag, "_update"}, 256'(mmif.mm_update), 256'd0);
  endtask

  logic [255:0] ex[NREQ];
  logic [255:0] ey[NREQ];

  initial begin
    int t, tc, ptr, exp_i;
    logic [NREQ-1:0] v;
    logic [255:0] d, x0, y0;
    logic e;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Single operation from requester 2.
    op_check("single", 2, 256'd2, 256'd3, 256'd6, 1'b0, L + 2);

    // All requesters from reset: rotation and 75-cycle spacing.
    @(posedge clk); #1;
    rstn = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      ex[i] = rnd256();
      ey[i] = rnd256();
      req_x[i*DW +: DW] = ex[i];
      req_y[i*DW +: DW] = ey[i];
    end
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    clear_logs();
    rstn = 1'b1;
    for (int k = 0; k < 600 && g_cyc.size() < 5; k++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 200 && r_cyc.size() < 5; k++) @(negedge clk);
    check_eq("rot_grants", 256'(g_cyc.size()), 256'd5);
    check_eq("rot_rsps", 256'(r_cyc.size()), 256'd5);
    ptr = NREQ - 1;
    for (int k = 0; k < 5; k++) begin
      exp_i = rr_pick('1, ptr);
      if (k < g_cyc.size() && k < r_cyc.size()) begin
        check_eq($sformatf("rot_gnt%0d", k), 256'(g_vec[k]), 256'(1 << exp_i));
        if (k > 0) check_eq($sformatf("rot_gap%0d", k), 256'(g_cyc[k] - g_cyc[k-1]), 256'(L + 3));
        check_eq($sformatf("rot_rcyc%0d", k), 256'(r_cyc[k]), 256'(g_cyc[k] + L + 2));
        check_eq($sformatf("rot_rvec%0d", k), 256'(r_vec[k]), 256'(1 << exp_i));
        check_eq($sformatf("rot_rdat%0d", k), r_data[k], mulmod(ex[exp_i], ey[exp_i]));
      end
      ptr = exp_i;
    end
    repeat (5) @(posedge clk);

    // Operand stability: owner changes its x while the engine is working.
    x0 = rnd256();
    y0 = rnd256();
    clear_logs();
    issue(3, x0, y0, t);
    repeat (10) @(posedge clk);
    #1;
    req_x[3*DW +: DW] = ~x0;
    repeat (20) @(negedge clk);
    check_eq("stab_datax_wait", mmif.mm_datax, x0);
    check_eq("stab_busy", 256'(busy), 256'd1);
    wait_rsp(L + 40, tc, v, d, e);
    check_eq("stab_datax_resp", mmif.mm_datax, x0);
    check_eq("stab_vec", 256'(v), 256'b1000);
    check_eq("stab_data", d, mulmod(x0, y0));

    // Watchdog timeout, then normal service with sticky flag.
    never_done = 1'b1;
    op_check("tmo", 1, rnd256(), rnd256(), 256'd0, 1'b1, 257);
    check_eq("tmo_sticky", 256'(timeout_err), 256'd1);
    never_done = 1'b0;
    x0 = rnd256();
    y0 = rnd256();
    op_check("post_tmo", 0, x0, y0, mulmod(x0, y0), 1'b0, L + 2);
    check_eq("tmo_sticky2", 256'(timeout_err), 256'd1);

    // Spurious done in IDLE is ignored.
    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    repeat (2) @(posedge clk);
    op_check("spur", 1, MODZ - 256'd1, MODZ - 256'd1, 256'd1, 1'b0, L + 2);

    // Randomized requesters and operands.
    for (int n = 0; n < 6; n++) begin
      int r;
      r  = $urandom_range(0, NREQ - 1);
      x0 = rnd256();
      y0 = rnd256();
      op_check($sformatf("rand%0d", n), r, x0, y0, mulmod(x0, y0), 1'b0, L + 2);
    end

    // Reset 30 cycles after grant drops the owner silently.
    clear_logs();
    issue(2, rnd256(), rnd256(), t);
    repeat (29) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    clear_logs();
    repeat (100) @(negedge clk);
    check_eq("midrst_no_rsp", 256'(r_cyc.size()), 256'd0);
    x0 = rnd256();
    y0 = rnd256();
    op_check("after_rst", 0, x0, y0, mulmod(x0, y0), 1'b0, L + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end
endmodule
